serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition sequencer for the shared single-bit `fulladder` cell. On a start request it latches two WIDTH-bit operands and a carry-in, then feeds the full adder one bit per clock, LSB first, through its `fa_*` ports. It recirculates the carry through an internal flip-flop and assembles the sum in a shift register. A one-cycle `done` pulse reports completion, after which `sum`/`cout` hold until the next operation. It sits between the test/LFSR control logic and the full-adder datapath and owns that datapath exclusively.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Must be ≥ 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE.
- `a` input WIDTH: operand A; latched at the accepting edge.
- `b` input WIDTH: operand B; latched at the accepting edge.
- `cin` input 1: carry-in; latched at the accepting edge.
- `fa_i0` output 1: to full adder `i0`; current bit of A.
- `fa_i1` output 1: to full adder `i1`; current bit of B.
- `fa_ci` output 1: to full adder `ci`; carry flip-flop.
- `fa_s` input 1: from full adder `s`.
- `fa_co` input 1: from full adder `co`.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse; result valid.
- `sum` output WIDTH: registered result.
- `cout` output 1: registered final carry.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, `fa_*` outputs=0. Shift registers, carry flip-flop and bit counter clear to 0.
- IDLE with `start`=1 at an edge:
  - `a_sh`←`a`, `b_sh`←`b`, `carry`←`cin`, `cnt`←0.
  - Go to RUN.
- IDLE with `start`=0: stay in IDLE.
- RUN, combinational drive: `fa_i0`=`a_sh[0]`, `fa_i1`=`b_sh[0]`, `fa_ci`=`carry`.
- RUN, each edge:
  - `a_sh`, `b_sh` shift right.
  - `s_sh` ← {`fa_s`, `s_sh[WIDTH-1:1]`}.
  - `carry`←`fa_co`, `cnt`←`cnt`+1.
- RUN exit: at the edge where `cnt`==WIDTH-1:
  - `sum`←{`fa_s`, `s_sh[WIDTH-1:1]`}, `cout`←`fa_co`.
  - Go to DONE.
- DONE: `done`=1 for exactly one cycle; unconditionally return to IDLE.
- `fa_*` outputs are 0 outside RUN.
- `start` is ignored in RUN and DONE, and is not queued.
- `a`/`b`/`cin` changes after the accepting edge have no effect.
- `sum`/`cout` change only at the RUN→DONE edge and otherwise hold.
- Arithmetic: {`cout`,`sum`} = `a`+`b`+`cin`, modulo 2^(WIDTH+1).
- `cnt` width is clog2(WIDTH). No wrap is visible.
- Async reset mid-operation aborts immediately: no `done` pulse, and all outputs return to reset values.

## Timing
- E0 is the edge accepting `start`.
- `busy`=1 from E0 through E_WIDTH, i.e. exactly WIDTH cycles.
- Bit k is presented on `fa_*` between E_k and E_{k+1}, and captured at E_{k+1}.
- `sum`/`cout` are valid and `done`=1 from E_WIDTH to E_{WIDTH+1}.
- Start-to-done latency: WIDTH edges.
- Earliest next accept is E_{WIDTH+2}. With `start` held high, one operation completes every WIDTH+2 cycles.
- The full adder is combinational. The `fa_s`/`fa_co` path is a single-cycle path from `fa_*` flops through the adder to the internal flops.

## Test plan
- Basic add: WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0 -> `done` at E8; `sum`=0x96, `cout`=0; `busy` high for exactly 8 cycles.
- Carry ripple: `a`=0xFF, `b`=0x01, `cin`=0 -> `sum`=0x00, `cout`=1.
- Carry-in path: `a`=0xFF, `b`=0x00, `cin`=1 -> `sum`=0x00, `cout`=1.
- Per-bit probe: during the run, `fa_i0`/`fa_i1` follow `a`/`b` LSB first, and `fa_ci` equals the previous `fa_co`.
- Back-to-back: `start` held high across three operations (0x01+0x01, 0x80+0x80, 0x12+0x34) -> `done` at E8, E18, E28 with results 0x02/0, 0x00/1, 0x46/0.
  - A `start` pulse and operand changes during RUN are ignored.
- Reset mid-operation: assert `rst_n`=0 between E4 and E5 -> `busy`, `done`, `sum`, `cout` and `fa_*` go to 0 immediately, with no `done` pulse.
  - A new start after release produces a correct result.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add sequencer driving a shared single-bit full adder
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_i0,
    output logic             fa_i1,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic            carry;
    logic [CW-1:0]   cnt;

    // busy is high exactly in RUN, so it gates the adder drive to zero elsewhere
    assign fa_i0 = busy & a_sh[0];
    assign fa_i1 = busy & b_sh[0];
    assign fa_ci = busy & carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    // last bit: publish the assembled word directly from the adder output
                    if (cnt == LAST) begin
                        sum   <= {fa_s, s_sh[WIDTH-1:1]};
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with a behavioural full adder
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         fa_i0, fa_i1, fa_ci, fa_s, fa_co;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .fa_i0(fa_i0), .fa_i1(fa_i1), .fa_ci(fa_ci), .fa_s(fa_s), .fa_co(fa_co),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    assign fa_s  = fa_i0 ^ fa_i1 ^ fa_ci;
    assign fa_co = (fa_i0 & fa_i1) | (fa_i0 & fa_ci) | (fa_i1 & fa_ci);

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        int           acc;
    } op_t;

    op_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_acc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rst_n && !busy && !done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          input bit hold, input int gap_exp);
        bit       ok;
        logic [W:0] r;
        op_t      o;
        wait_idle(ok);
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy=%b done=%b expected idle", busy, done);
            return;
        end
        a = ia; b = ib; cin = ic; start = 1'b1;
        r = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        o.a = ia; o.b = ib; o.cin = ic; o.sum = r[W-1:0]; o.cout = r[W]; o.acc = cyc + 1;
        q.push_back(o);
        if (gap_exp > 0) chk("accept_gap", o.acc - last_acc, gap_exp);
        last_acc = o.acc;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            if (!hold) start = 1'($urandom);
        end
        if (!hold) start = 1'b0;
    endtask

    op_t          mo;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    int           bcnt = 0;
    logic         prev_co = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_sum = '0; last_cout = 1'b0; bcnt = 0;
        end else begin
            if (!done) begin
                chk("sum_hold", sum, last_sum);
                chk("cout_hold", cout, last_cout);
            end
            if (busy) begin
                if (q.size() == 0 || bcnt >= W) begin
                    errors++;
                    $display("FAIL busy_unexpected: busy=1 after %0d bits, %0d ops pending", bcnt, q.size());
                end else begin
                    chk("fa_i0", fa_i0, q[0].a[bcnt]);
                    chk("fa_i1", fa_i1, q[0].b[bcnt]);
                    chk("fa_ci", fa_ci, (bcnt == 0) ? q[0].cin : prev_co);
                end
                prev_co = fa_co;
                bcnt++;
            end else begin
                chk("fa_idle", {fa_i0, fa_i1, fa_ci}, 3'b000);
                if (done) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected: done=1 with no operation pending");
                    end else begin
                        mo = q.pop_front();
                        chk("sum", sum, mo.sum);
                        chk("cout", cout, mo.cout);
                        chk("busy_cycles", bcnt, W);
                        chk("latency", cyc - mo.acc, W);
                        last_sum = mo.sum;
                        last_cout = mo.cout;
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit prev_hold;
        bit hold;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", {busy, done, cout, sum, fa_i0, fa_i1, fa_ci}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0);

        run_op(8'h01, 8'h01, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 1'b1, W + 2);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, W + 2);

        wait_idle(ok);
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle_reset: busy=%b done=%b expected idle", busy, done);
        end
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        q.push_back('{a: 8'h77, b: 8'h11, cin: 1'b0, sum: 8'h88, cout: 1'b0, acc: cyc + 1});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {busy, done}, 2'b00);
        chk("abort_sum_cout", {cout, sum}, '0);
        chk("abort_fa", {fa_i0, fa_i1, fa_ci}, 3'b000);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h77, 8'h11, 1'b1, 1'b0, 0);

        prev_hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            hold = (i < 19) ? 1'($urandom) : 1'b0;
            run_op(W'($urandom), W'($urandom), 1'($urandom), hold, prev_hold ? W + 2 : 0);
            prev_hold = hold;
        end

        wait_idle(ok);
        if (!ok) begin
            errors++;
            $display("FAIL drain: busy=%b done=%b expected idle", busy, done);
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
